// File: rtl/counter_ctrl.sv
// counter_ctrl: round-robin arbiter for two requesters that share one 4-bit
// counter. The winner owns the counter for a RUN phase. During that phase the
// counter steps from 0 up to the winner's terminal count. After RUN, a
// one-cycle DONE phase pulses done to the winner.
//
// Optional feature macro: COUNTER_CTRL_PAUSE_EN
//   defined   -> pause port present; pause high in RUN freezes count and state
//   undefined -> no pause port; RUN counts every cycle
//
// Ports
//   clk     in   1  system clock, rising edge
//   reset   in   1  asynchronous active-low reset
//   req     in   2  level requests, bit i = requester i
//   limit0  in   4  terminal count for requester 0, sampled at grant
//   limit1  in   4  terminal count for requester 1, sampled at grant
//   pause   in   1  hold counting in RUN (only with COUNTER_CTRL_PAUSE_EN)
//   gnt     out  2  one-hot grant, high for the whole RUN phase
//   busy    out  1  high whenever not IDLE
//   done    out  2  one-cycle completion pulse to the served requester
//   count   out  4  shared counter value
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no owner; arbitrates on any request
// RUN   | winner owns the counter, count steps 0..latched limit
// DONE  | one-cycle completion pulse to winner, counter cleared

module counter_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic [3:0] limit0,
  input  logic [3:0] limit1,
`ifdef COUNTER_CTRL_PAUSE_EN
  input  logic       pause,
`endif
  output logic [1:0] gnt,
  output logic       busy,
  output logic [1:0] done,
  output logic [3:0] count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic       winner, winner_nxt;
  logic       prio, prio_nxt;
  logic [3:0] lim, lim_nxt;
  logic [3:0] count_nxt;
  logic       pick;
  logic       hold;

`ifdef COUNTER_CTRL_PAUSE_EN
  assign hold = pause;
`else
  assign hold = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      winner <= 1'b0;
      prio   <= 1'b0;
      lim    <= 4'd0;
      count  <= 4'd0;
    end else begin
      state  <= state_nxt;
      winner <= winner_nxt;
      prio   <= prio_nxt;
      lim    <= lim_nxt;
      count  <= count_nxt;
    end
  end

  // A lone request wins outright; the priority pointer only breaks ties.
  assign pick = (req == 2'b11) ? prio : req[1];

  always_comb begin
    state_nxt  = state;
    winner_nxt = winner;
    prio_nxt   = prio;
    lim_nxt    = lim;
    count_nxt  = count;
    case (state)
      IDLE: begin
        count_nxt = 4'd0;
        if (req != 2'b00) begin
          winner_nxt = pick;
          lim_nxt    = pick ? limit1 : limit0;
          prio_nxt   = ~pick;
          state_nxt  = RUN;
        end
      end
      RUN: begin
        // Abort has precedence over pause and over reaching the limit.
        if (!req[winner]) begin
          state_nxt = IDLE;
          count_nxt = 4'd0;
        end else if (hold) begin
          count_nxt = count;
        end else if (count == lim) begin
          state_nxt = DONE;
          count_nxt = 4'd0;
        end else begin
          count_nxt = count + 4'd1;
        end
      end
      DONE: begin
        state_nxt = IDLE;
        count_nxt = 4'd0;
      end
      default: begin
        state_nxt = IDLE;
        count_nxt = 4'd0;
      end
    endcase
  end

  always_comb begin
    gnt  = 2'b00;
    done = 2'b00;
    busy = (state != IDLE);
    if (state == RUN)  gnt[winner]  = 1'b1;
    if (state == DONE) done[winner] = 1'b1;
  end

endmodule

// File: tb/tb_counter_ctrl.sv
module tb_counter_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] req = 2'b00;
  logic [3:0] limit0 = 4'd0;
  logic [3:0] limit1 = 4'd0;
`ifdef COUNTER_CTRL_PAUSE_EN
  logic       pause = 1'b0;
`endif
  logic [1:0] gnt;
  logic       busy;
  logic [1:0] done;
  logic [3:0] count;

  counter_ctrl dut (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .limit0 (limit0),
    .limit1 (limit1),
`ifdef COUNTER_CTRL_PAUSE_EN
    .pause  (pause),
`endif
    .gnt    (gnt),
    .busy   (busy),
    .done   (done),
    .count  (count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    bit         rst_first;
    logic [1:0] req;
    logic [3:0] l0;
    logic [3:0] l1;
    logic [1:0] gnt;
    logic       busy;
    logic [1:0] done;
    logic [3:0] cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit rf, logic [1:0] r, logic [3:0] a, logic [3:0] b,
                              logic [1:0] g, logic bz, logic [1:0] d, logic [3:0] c);
    vec_t v;
    v.rst_first = rf; v.req = r; v.l0 = a; v.l1 = b;
    v.gnt = g; v.busy = bz; v.done = d; v.cnt = c;
    return v;
  endfunction

  task automatic chk(string name, logic [1:0] eg, logic eb, logic [1:0] ed, logic [3:0] ec);
    n_cmp++;
    if (gnt !== eg || busy !== eb || done !== ed || count !== ec) begin
      n_bad++;
      $display("FAIL %s: got gnt=%b busy=%b done=%b count=%0d, want gnt=%b busy=%b done=%b count=%0d",
               name, gnt, busy, done, count, eg, eb, ed, ec);
    end
  endtask

  task automatic cmp_int(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds reset across one edge, releases it between edges.
  task automatic do_reset();
    reset = 1'b0;
    #1;
    chk("reset_state", 2'b00, 1'b0, 2'b00, 4'd0);
    @(posedge clk);
    #3;
    reset = 1'b1;
  endtask

  // Reference model: m_k is the number of cycles elapsed since the grant
  // (-1 when idle). 0..lim is the RUN window with count == m_k, lim+1 is the
  // done pulse.
  int m_k, m_lim, m_owner, m_prio;

  task automatic model_reset();
    m_k = -1; m_lim = 0; m_owner = 0; m_prio = 0;
  endtask

  task automatic model_edge(logic [1:0] r, logic [3:0] l0, logic [3:0] l1);
    int w;
    if (m_k < 0) begin
      if (r != 2'b00) begin
        w = (r == 2'b11) ? m_prio : (r[0] ? 0 : 1);
        m_owner = w;
        m_lim = (w == 1) ? int'(l1) : int'(l0);
        m_prio = 1 - w;
        m_k = 0;
      end
    end else if (m_k <= m_lim) begin
      if (!r[m_owner]) m_k = -1;
      else m_k = m_k + 1;
    end else begin
      m_k = -1;
    end
  endtask

  task automatic model_chk(string name);
    logic [1:0] eg, ed;
    logic [3:0] ec;
    logic       eb;
    bit         run;
    run = (m_k >= 0) && (m_k <= m_lim);
    eg  = run ? ((m_owner == 1) ? 2'b10 : 2'b01) : 2'b00;
    ec  = run ? 4'(m_k) : 4'd0;
    ed  = (m_k == m_lim + 1) ? ((m_owner == 1) ? 2'b10 : 2'b01) : 2'b00;
    eb  = (m_k >= 0);
    chk(name, eg, eb, ed, ec);
  endtask

  initial begin
    // Contention from reset: r0 (limit 1), r1 (limit 2), then r0 again.
    tbl.push_back(mk(1, 2'b11, 4'd1, 4'd2, 2'b01, 1, 2'b00, 4'd0));
    tbl.push_back(mk(0, 2'b11, 4'd1, 4'd2, 2'b01, 1, 2'b00, 4'd1));
    tbl.push_back(mk(0, 2'b11, 4'd1, 4'd2, 2'b00, 1, 2'b01, 4'd0));
    tbl.push_back(mk(0, 2'b11, 4'd1, 4'd2, 2'b00, 0, 2'b00, 4'd0));
    tbl.push_back(mk(0, 2'b11, 4'd1, 4'd2, 2'b10, 1, 2'b00, 4'd0));
    tbl.push_back(mk(0, 2'b11, 4'd1, 4'd2, 2'b10, 1, 2'b00, 4'd1));
    tbl.push_back(mk(0, 2'b11, 4'd1, 4'd2, 2'b10, 1, 2'b00, 4'd2));
    tbl.push_back(mk(0, 2'b11, 4'd1, 4'd2, 2'b00, 1, 2'b10, 4'd0));
    tbl.push_back(mk(0, 2'b11, 4'd1, 4'd2, 2'b00, 0, 2'b00, 4'd0));
    tbl.push_back(mk(0, 2'b11, 4'd1, 4'd2, 2'b01, 1, 2'b00, 4'd0));
    // Single request r0, limit 3.
    tbl.push_back(mk(1, 2'b01, 4'd3, 4'd0, 2'b01, 1, 2'b00, 4'd0));
    tbl.push_back(mk(0, 2'b01, 4'd3, 4'd0, 2'b01, 1, 2'b00, 4'd1));
    tbl.push_back(mk(0, 2'b01, 4'd3, 4'd0, 2'b01, 1, 2'b00, 4'd2));
    tbl.push_back(mk(0, 2'b01, 4'd3, 4'd0, 2'b01, 1, 2'b00, 4'd3));
    tbl.push_back(mk(0, 2'b01, 4'd3, 4'd0, 2'b00, 1, 2'b01, 4'd0));
    tbl.push_back(mk(0, 2'b00, 4'd3, 4'd0, 2'b00, 0, 2'b00, 4'd0));
    tbl.push_back(mk(0, 2'b00, 4'd3, 4'd0, 2'b00, 0, 2'b00, 4'd0));
    // Limit zero on r1.
    tbl.push_back(mk(0, 2'b10, 4'd5, 4'd0, 2'b10, 1, 2'b00, 4'd0));
    tbl.push_back(mk(0, 2'b10, 4'd5, 4'd0, 2'b00, 1, 2'b10, 4'd0));
    tbl.push_back(mk(0, 2'b00, 4'd5, 4'd0, 2'b00, 0, 2'b00, 4'd0));

    for (int i = 0; i < tbl.size(); i++) begin
      req = tbl[i].req; limit0 = tbl[i].l0; limit1 = tbl[i].l1;
      if (tbl[i].rst_first) do_reset();
      tick();
      chk($sformatf("vec%0d", i), tbl[i].gnt, tbl[i].busy, tbl[i].done, tbl[i].cnt);
    end

    // Abort at count 4; limit0 change mid-run must be ignored.
    begin
      int n;
      bit saw_done;
      req = 2'b01; limit0 = 4'd9; limit1 = 4'd0;
      do_reset();
      tick();
      limit0 = 4'd2;
      n = 0; saw_done = 0;
      while (count != 4'd4 && n < 20) begin
        if (done != 2'b00) saw_done = 1;
        tick();
        n++;
      end
      cmp_int("abort_reach4", int'(count), 4);
      chk("abort_at4", 2'b01, 1'b1, 2'b00, 4'd4);
      req = 2'b00;
      tick();
      chk("abort_idle", 2'b00, 1'b0, 2'b00, 4'd0);
      for (int k = 0; k < 3; k++) begin
        if (done != 2'b00) saw_done = 1;
        tick();
      end
      cmp_int("abort_no_done", int'(saw_done), 0);
    end

    // Reset mid-run at count 5; priority returns to requester 0.
    begin
      int n;
      req = 2'b01; limit0 = 4'd9;
      do_reset();
      n = 0;
      while (count != 4'd5 && n < 20) begin
        tick();
        n++;
      end
      cmp_int("rst_reach5", int'(count), 5);
      #2;
      reset = 1'b0;
      #1;
      chk("rst_mid_run", 2'b00, 1'b0, 2'b00, 4'd0);
      req = 2'b11;
      @(posedge clk);
      #3;
      reset = 1'b1;
      tick();
      chk("rst_first_arb", 2'b01, 1'b1, 2'b00, 4'd0);
    end

`ifdef COUNTER_CTRL_PAUSE_EN
    // Pause two cycles at count 1.
    req = 2'b01; limit0 = 4'd3; pause = 1'b0;
    do_reset();
    tick(); chk("pause_c0", 2'b01, 1'b1, 2'b00, 4'd0);
    tick(); chk("pause_c1", 2'b01, 1'b1, 2'b00, 4'd1);
    pause = 1'b1;
    tick(); chk("pause_h1", 2'b01, 1'b1, 2'b00, 4'd1);
    tick(); chk("pause_h2", 2'b01, 1'b1, 2'b00, 4'd1);
    pause = 1'b0;
    tick(); chk("pause_c2", 2'b01, 1'b1, 2'b00, 4'd2);
    tick(); chk("pause_c3", 2'b01, 1'b1, 2'b00, 4'd3);
    tick(); chk("pause_done", 2'b00, 1'b1, 2'b01, 4'd0);
    req = 2'b00;
    tick();
`endif

    // Random stimulus against the reference model.
    req = 2'b00;
    do_reset();
    model_reset();
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 7) == 0) req = 2'($urandom_range(0, 3));
      limit0 = 4'($urandom_range(0, 6));
      limit1 = 4'($urandom_range(0, 6));
      @(posedge clk);
      model_edge(req, limit0, limit1);
      #1;
      model_chk("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
